// File: rtl/beamsum_pkg.sv
// Shared widths and the serialiser state encoding for the beamformer UART
// transmit path.
package beamsum_pkg;

   localparam int SAMPLE_W         = 40;
   localparam int BYTES_PER_SAMPLE = 5;
   localparam int UART_DATA_BITS   = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } tx_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO with extended pointers, full/empty/count and a registered
// read port that captures the head entry on each pop.
module sample_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] rd_data_q;
   logic             do_push, do_pop;

   // Pushes are refused while full even if a pop happens in the same cycle.
   always_comb begin
      count    = wr_ptr_q - rd_ptr_q;
      full     = (count == DEPTH_CNT);
      empty    = (count == '0);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
      if (do_pop)  rd_data_q <= mem[rd_ptr_q[AW-1:0]];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/beamsum_uart_tx.sv
// Buffers 40-bit beamformer sums and sends each as five little-endian UART
// bytes (start, 8 data LSB first, STOP_BITS stop bits).
module beamsum_uart_tx import beamsum_pkg::*; #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 1024,
   parameter int STOP_BITS    = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [SAMPLE_W-1:0]           sample_data,
   input  logic                          sample_valid,
   output logic                          sample_ready,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int BAUD_W = $clog2(STOP_BITS * CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1);
   localparam logic [2:0] DATA_LAST = 3'(UART_DATA_BITS - 1);
   localparam logic [2:0] BYTE_LAST = 3'(BYTES_PER_SAMPLE - 1);

   tx_state_e             state_q, state_d;
   logic [BAUD_W-1:0]     baud_q, baud_d;
   logic [2:0]            bit_q, bit_d;
   logic [2:0]            byte_q, byte_d;
   logic [SAMPLE_W-1:0]   shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  overflow_q, overflow_d;
   logic                  fifo_pop, fifo_full, fifo_empty;
   logic [SAMPLE_W-1:0]   fifo_rd_data;

   sample_fifo #(
      .WIDTH (SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (sample_valid),
      .wr_data (sample_data),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // The FIFO read register only becomes valid after the LOAD pop, so the
   // shift register picks up the head during the first byte's start bit.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      byte_d   = byte_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = LOAD;
         end
         LOAD: begin
            fifo_pop = 1'b1;
            baud_d   = '0;
            bit_d    = '0;
            byte_d   = '0;
            state_d  = START;
         end
         START: begin
            if (byte_q == '0) shift_d = fifo_rd_data;
            if (baud_q == BIT_LAST) begin
               baud_d  = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_q == BIT_LAST) begin
               baud_d = '0;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_q == STOP_LAST) begin
               baud_d = '0;
               if (byte_q < BYTE_LAST) begin
                  byte_d  = byte_q + 1'b1;
                  shift_d = shift_q >> UART_DATA_BITS;
                  state_d = START;
               end else begin
                  byte_d  = '0;
                  state_d = fifo_empty ? IDLE : LOAD;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level follows the state being entered so tx is a clean flop.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[bit_d];
         default: tx_d = 1'b1;
      endcase

      overflow_d = overflow_q | (sample_valid & fifo_full);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         byte_q     <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         byte_q     <= byte_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         overflow_q <= overflow_d;
      end
   end

   assign tx           = tx_q;
   assign overflow     = overflow_q;
   assign sample_ready = !fifo_full;
   assign busy         = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_beamsum_uart_tx.sv
// Drives two transmitters (1 and 2 stop bits) and decodes their lines with a
// bit-level UART receiver, comparing bytes, framing and timing to expectations.
module tb_beamsum_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [39:0] sampleData [2];
   logic [1:0]  sampleValid;
   logic [1:0]  sampleReady, tx, busy, overflow;
   logic [2:0]  fifoCountA, fifoCountB;

   int cyc = 0;
   int testsRun = 0;
   int testsFailed = 0;

   logic [39:0] rxVal    [2][16];
   int          rxStart  [2][16];
   int          rxEnd    [2][16];
   bit          rxContig [2][16];
   int          rxCount  [2] = '{0, 0};
   int          frameErr [2] = '{0, 0};

   beamsum_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dutA (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_data  (sampleData[0]),
      .sample_valid (sampleValid[0]),
      .sample_ready (sampleReady[0]),
      .tx           (tx[0]),
      .busy         (busy[0]),
      .overflow     (overflow[0]),
      .fifo_count   (fifoCountA)
   );

   beamsum_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dutB (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_data  (sampleData[1]),
      .sample_valid (sampleValid[1]),
      .sample_ready (sampleReady[1]),
      .tx           (tx[1]),
      .busy         (busy[1]),
      .overflow     (overflow[1]),
      .fifo_count   (fifoCountB)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Called just after a falling edge; offers one sample for one rising edge.
   task automatic applyStimulus(input int idx, input logic [39:0] value,
                                output logic readySeen, output int edgeCyc);
      sampleData[idx]  = value;
      sampleValid[idx] = 1'b1;
      readySeen        = sampleReady[idx];
      @(posedge clk);
      #1 edgeCyc = cyc;
      @(negedge clk);
      sampleValid[idx] = 1'b0;
   endtask

   task automatic waitRx(input int idx, input int n, input int limit);
      int k;
      k = 0;
      while (rxCount[idx] < n && k < limit) begin
         @(negedge clk);
         k++;
      end
      checkOutput("rxCount", 64'(rxCount[idx]), 64'(n));
   endtask

   // Receiver: every bit must hold one level for all CPB samples; five bytes
   // are reassembled little-endian into one 40-bit value.
   task automatic monitorLine(input int idx, input int stopBits);
      logic [39:0] acc;
      logic [7:0]  data;
      logic        lvl, firstLvl;
      int          nb, byteStart, prevStart, firstStart;
      bit          bad, aborted, contig;
      acc = '0; nb = 0; prevStart = 0; firstStart = 0; contig = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) nb = 0;
         else if (tx[idx] === 1'b0) begin
            byteStart = cyc; bad = 1'b0; aborted = 1'b0; data = '0; firstLvl = 1'b0;
            for (int b = 0; b < 9 + stopBits; b++) begin
               for (int c = 0; c < CPB; c++) begin
                  if (b != 0 || c != 0) @(negedge clk);
                  if (!rst_n) aborted = 1'b1;
                  lvl = tx[idx];
                  if (c == 0) firstLvl = lvl;
                  else if (lvl !== firstLvl) bad = 1'b1;
               end
               if (b == 0 && firstLvl !== 1'b0) bad = 1'b1;
               else if (b >= 1 && b <= 8) data[b-1] = firstLvl;
               else if (b > 8 && firstLvl !== 1'b1) bad = 1'b1;
            end
            if (aborted) nb = 0;
            else begin
               if (bad) frameErr[idx]++;
               if (nb == 0) begin
                  firstStart = byteStart;
                  contig = 1'b1;
               end else if (byteStart - prevStart != (9 + stopBits) * CPB) begin
                  contig = 1'b0;
               end
               acc[8*nb +: 8] = data;
               prevStart = byteStart;
               nb++;
               if (nb == 5) begin
                  if (rxCount[idx] < 16) begin
                     rxVal[idx][rxCount[idx]]    = acc;
                     rxStart[idx][rxCount[idx]]  = firstStart;
                     rxEnd[idx][rxCount[idx]]    = cyc;
                     rxContig[idx][rxCount[idx]] = contig;
                  end
                  rxCount[idx]++;
                  nb = 0;
               end
            end
         end
      end
   endtask

   initial monitorLine(0, 1);
   initial monitorLine(1, 2);

   initial begin
      logic [39:0] v;
      logic [39:0] vals [3];
      logic [39:0] expQ [$];
      logic        rdy;
      int          e, e0, s, accepted, pops;

      sampleValid   = '0;
      sampleData[0] = '0;
      sampleData[1] = '0;
      #1 rst_n = 1'b0;
      #2;
      checkOutput("rstTx",       64'(tx),          64'(2'b11));
      checkOutput("rstReady",    64'(sampleReady), 64'(2'b11));
      checkOutput("rstBusy",     64'(busy),        64'(0));
      checkOutput("rstOverflow", 64'(overflow),    64'(0));
      checkOutput("rstCountA",   64'(fifoCountA),  64'(0));
      checkOutput("rstCountB",   64'(fifoCountB),  64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Known pattern: byte order, first-edge latency, frame length, busy drop
      rxCount[0] = 0;
      applyStimulus(0, 40'h12_3456_789A, rdy, e);
      checkOutput("readyIdle", 64'(rdy), 64'(1));
      while (cyc < e + 201) @(negedge clk);
      checkOutput("busyLastStop", 64'(busy[0]), 64'(1));
      @(negedge clk);
      checkOutput("busyDrop", 64'(busy[0]), 64'(0));
      checkOutput("txIdle",   64'(tx[0]),   64'(1));
      waitRx(0, 1, 50);
      checkOutput("byteOrder",    64'(rxVal[0][0]), 64'(40'h12_3456_789A));
      checkOutput("startLatency", 64'(rxStart[0][0] - e), 64'(2));
      checkOutput("frameLen",     64'(rxEnd[0][0] - rxStart[0][0] + 1), 64'(200));
      checkOutput("contig",       64'(rxContig[0][0]), 64'(1));

      // All-ones (negative) sample
      rxCount[0] = 0;
      applyStimulus(0, 40'hFF_FFFF_FFFF, rdy, e);
      waitRx(0, 1, 400);
      checkOutput("negValue", 64'(rxVal[0][0]), 64'(40'hFF_FFFF_FFFF));
      repeat (3) @(negedge clk);

      // Random single samples
      for (int i = 0; i < 3; i++) begin
         v = {8'($urandom()), 32'($urandom())};
         rxCount[0] = 0;
         applyStimulus(0, v, rdy, e);
         waitRx(0, 1, 400);
         checkOutput("randValue",  64'(rxVal[0][0]), 64'(v));
         checkOutput("randContig", 64'(rxContig[0][0]), 64'(1));
         repeat (3) @(negedge clk);
         checkOutput("randIdle", 64'(busy[0]), 64'(0));
      end

      // Back-to-back: one LOAD cycle between consecutive samples
      rxCount[0] = 0;
      for (int i = 0; i < 3; i++) begin
         vals[i] = {8'($urandom()), 32'($urandom())};
         applyStimulus(0, vals[i], rdy, e);
         if (i == 0) e0 = e;
      end
      waitRx(0, 3, 1000);
      checkOutput("b2bLatency", 64'(rxStart[0][0] - e0), 64'(2));
      for (int i = 0; i < 3; i++) begin
         checkOutput("b2bValue",  64'(rxVal[0][i]), 64'(vals[i]));
         checkOutput("b2bContig", 64'(rxContig[0][i]), 64'(1));
         if (i > 0) checkOutput("b2bGap", 64'(rxStart[0][i] - rxEnd[0][i-1]), 64'(2));
      end
      repeat (5) @(negedge clk);

      // Burst 0..5 into a 4-deep FIFO; the first sample leaves 2 edges after
      // its push, so exactly one pop happens during the burst.
      rxCount[0] = 0;
      accepted = 0;
      for (int k = 0; k < 6; k++) begin
         pops = (k >= 3) ? 1 : 0;
         applyStimulus(0, 40'(k), rdy, e);
         checkOutput("burstReady", 64'(rdy), 64'((accepted - pops) != DEPTH));
         if ((accepted - pops) != DEPTH) begin
            expQ.push_back(40'(k));
            accepted++;
         end
         pops = (k >= 2) ? 1 : 0;
         checkOutput("burstCount", 64'(fifoCountA), 64'(accepted - pops));
      end
      checkOutput("overflowSet", 64'(overflow[0]), 64'(1));
      waitRx(0, expQ.size(), 1500);
      for (int i = 0; i < expQ.size(); i++) begin
         checkOutput("burstValue",  64'(rxVal[0][i]), 64'(expQ[i]));
         checkOutput("burstContig", 64'(rxContig[0][i]), 64'(1));
      end
      checkOutput("overflowSticky", 64'(overflow[0]), 64'(1));
      repeat (3) @(negedge clk);
      checkOutput("burstDrained", 64'(fifoCountA), 64'(0));

      // Reset during bit 3 of byte 2 (data bit forced to 0 beforehand)
      rxCount[0] = 0;
      v = {8'($urandom()), 32'($urandom())};
      v[19] = 1'b0;
      applyStimulus(0, v, rdy, e);
      s = e + 2;
      while (cyc < s + 97) @(negedge clk);
      checkOutput("preResetTx", 64'(tx[0]), 64'(0));
      rst_n = 1'b0;
      #1;
      checkOutput("midRstTx",       64'(tx[0]),       64'(1));
      checkOutput("midRstBusy",     64'(busy[0]),     64'(0));
      checkOutput("midRstCount",    64'(fifoCountA),  64'(0));
      checkOutput("midRstOverflow", 64'(overflow[0]), 64'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      checkOutput("noPartialFrame", 64'(rxCount[0]), 64'(0));
      v = {8'($urandom()), 32'($urandom())};
      applyStimulus(0, v, rdy, e);
      waitRx(0, 1, 400);
      checkOutput("postRstValue",   64'(rxVal[0][0]), 64'(v));
      checkOutput("postRstLatency", 64'(rxStart[0][0] - e), 64'(2));
      checkOutput("postRstContig",  64'(rxContig[0][0]), 64'(1));

      // Two stop bits: 5 x 11 bit times per sample
      rxCount[1] = 0;
      v = {8'($urandom()), 32'($urandom())};
      applyStimulus(1, v, rdy, e);
      while (cyc < e + 221) @(negedge clk);
      checkOutput("sb2BusyLast", 64'(busy[1]), 64'(1));
      @(negedge clk);
      checkOutput("sb2BusyDrop", 64'(busy[1]), 64'(0));
      waitRx(1, 1, 50);
      checkOutput("sb2Value",    64'(rxVal[1][0]), 64'(v));
      checkOutput("sb2Latency",  64'(rxStart[1][0] - e), 64'(2));
      checkOutput("sb2FrameLen", 64'(rxEnd[1][0] - rxStart[1][0] + 1), 64'(220));
      checkOutput("sb2Contig",   64'(rxContig[1][0]), 64'(1));

      checkOutput("frameErrA", 64'(frameErr[0]), 64'(0));
      checkOutput("frameErrB", 64'(frameErr[1]), 64'(0));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
